fifo_uart_tx: RTL
=================

Name: fifo_uart_tx

Overview:
Read-side consumer for the 8-bit synchronous FIFO. It pops bytes whenever the FIFO is non-empty and serialises each byte onto a UART TX line: 8N1, LSB first, idle-high. It sits downstream of the FIFO's read/empty/oData port and takes the place of the free-running reader in the FIFO bench, turning that bench into a loopback-capable byte pipe.

Parameters:
DATA_W, 8, FIFO word width and UART data bits per frame.
CLKS_PER_BIT, 16, CLK cycles per UART bit; legal range 2..65535.

Ports:
CLK  input  1  system clock; all logic on posedge.
RSTn  input  1  reset, asynchronous, active-low.
tx_en  input  1  permits starting new frames; a frame in progress always completes.
empty  input  1  FIFO empty flag.
fifo_data  input  DATA_W  FIFO oData; valid the cycle after a read pulse.
read  output  1  FIFO pop strobe; single-cycle pulse.
tx  output  1  UART serial out; idle 1.
busy  output  1  high from POP through the last STOP cycle.
frame_cnt  output  16  count of completed frames; wraps 0xFFFF->0.

Behaviour:
- Reset (asynchronous, immediate, including mid-frame):
  - tx=1, read=0, busy=0, frame_cnt=0.
  - FSM=IDLE; baud counter=0; bit index=0; shift register=0.
  - A frame cut short by reset is not resumed, and its byte is lost.
- FSM states: IDLE, POP, LOAD, START, DATA, STOP (plus PARITY under the optional feature).
- IDLE: if tx_en && !empty, go to POP; otherwise stay, with tx=1.
- POP: read=1 for exactly this cycle; go to LOAD unconditionally.
- LOAD: capture fifo_data into the shift register; go to START.
- START: tx=0 for CLKS_PER_BIT cycles; then go to DATA with bit index=0.
- DATA: tx=shift[0] for CLKS_PER_BIT cycles; then shift right and increment the bit index. After bit DATA_W-1, go to STOP.
- STOP: tx=1 for CLKS_PER_BIT cycles. On its last cycle:
  - increment frame_cnt;
  - if tx_en && !empty, go to POP, else go to IDLE.
- Baud counter: runs 0..CLKS_PER_BIT-1 and clears on every state entry. The bit-end tick is counter==CLKS_PER_BIT-1.
- Timing:
  - Latency from empty falling (tx_en=1) to read: 1 cycle.
  - Latency from read to the tx falling edge: 2 cycles.
  - Back-to-back frames have exactly 2 idle-high cycles (POP, LOAD) between the end of STOP and the next START.
- read is asserted only in POP. It is never asserted while empty=1 was sampled in the deciding cycle, so underflow cannot occur.
- empty rising during a frame has no effect on that frame.
- tx_en falling mid-frame: the frame finishes, then the FSM goes to IDLE.
- tx is registered, so there are no glitches.
- busy = (state != IDLE).

Optional Feature:
Macro FIFO_UART_TX_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP. tx carries the even-parity bit (XOR of all data bits) for CLKS_PER_BIT cycles. Frame length is 11 bits.
- Undefined: there is no PARITY state and no parity logic; the frame is 10 bits (8N1).

Decomposition:
- Package fifo_uart_pkg holds:
  - the state enum typedef (state_t);
  - the localparams FRAME_BITS_8N1=10 and FRAME_BITS_8E1=11;
  - the UART idle level constant (TX_IDLE=1'b1).
- One sub-module, uart_baud_ctr, is natural. It is a CLKS_PER_BIT-parameterised counter with a clr input and a tick output, and is instantiated once.

Test Plan:
1. Reset release with empty=1 and tx_en=1, held 100 cycles -> tx=1, read never asserted, busy=0, frame_cnt=0.
2. CLKS_PER_BIT=4, FIFO holding 0xA5, tx_en=1 -> one read pulse.
   - tx over 40 cycles: 0 | 1,0,1,0,0,1,0,1 | 1, each level held 4 cycles.
   - frame_cnt ends at 1; busy is high for 42 cycles.
3. FIFO holding 0x01,0x02,0x03 -> exactly 3 read pulses.
   - 3 frames decode to 01,02,03, with a 2-cycle high gap between frames.
   - frame_cnt=3, then IDLE.
4. tx_en dropped 10 cycles into a frame of 0x3C with 2 more bytes queued -> 0x3C completes, no further read, FSM IDLE, frame_cnt=1.
5. RSTn pulsed low in the DATA state of 0xFF -> tx=1 in the same cycle, busy=0, frame_cnt=0. After release with FIFO non-empty, a new frame starts cleanly.
6. With FIFO_UART_TX_PARITY_EN, send 0x07 -> parity bit=1 and 44-cycle frame at CLKS_PER_BIT=4. Without the macro, the frame is 40 cycles.

Source files
------------

// File: rtl/fifo_uart_pkg.sv
// rtl/fifo_uart_pkg.sv - shared state encoding and frame constants for the FIFO-fed UART transmitter
package fifo_uart_pkg;

   localparam int FRAME_BITS_8N1 = 10;
   localparam int FRAME_BITS_8E1 = 11;
   localparam logic TX_IDLE = 1'b1;

`ifdef FIFO_UART_TX_PARITY_EN
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      POP    = 3'd1,
      LOAD   = 3'd2,
      START  = 3'd3,
      DATA   = 3'd4,
      PARITY = 3'd5,
      STOP   = 3'd6
   } state_t;
`else
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      POP    = 3'd1,
      LOAD   = 3'd2,
      START  = 3'd3,
      DATA   = 3'd4,
      STOP   = 3'd6
   } state_t;
`endif

endpackage

// File: rtl/uart_baud_ctr.sv
// rtl/uart_baud_ctr.sv - bit-period counter; tick marks the last CLK cycle of a UART bit
module uart_baud_ctr #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic CLK,
   input  logic RSTn,
   input  logic clr,
   output logic tick
);

   localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);

   logic [15:0] cnt;

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         cnt <= '0;
      end else if (clr || tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 16'd1;
      end
   end

   assign tick = (cnt == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// rtl/fifo_uart_tx.sv - pops the FIFO and serialises each byte as UART 8N1 (8E1 with FIFO_UART_TX_PARITY_EN)
module fifo_uart_tx
   import fifo_uart_pkg::*;
#(
   parameter int DATA_W       = 8,
   parameter int CLKS_PER_BIT = 16
) (
   input  logic              CLK,
   input  logic              RSTn,
   input  logic              tx_en,
   input  logic              empty,
   input  logic [DATA_W-1:0] fifo_data,
   output logic              read,
   output logic              tx,
   output logic              busy,
   output logic [15:0]       frame_cnt
);

   localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

   state_t            state, state_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic              tx_d;
   logic              tick;
   logic              clr;
`ifdef FIFO_UART_TX_PARITY_EN
   logic              par_q, par_d;
`endif

   // Restart the bit period on every state change; DATA->DATA relies on the counter wrap.
   assign clr = (state_d != state);

   uart_baud_ctr #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud (
      .CLK (CLK),
      .RSTn(RSTn),
      .clr (clr),
      .tick(tick)
   );

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         state     <= IDLE;
         shift_q   <= '0;
         idx_q     <= '0;
         tx        <= TX_IDLE;
         frame_cnt <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
         par_q     <= 1'b0;
`endif
      end else begin
         state   <= state_d;
         shift_q <= shift_d;
         idx_q   <= idx_d;
         tx      <= tx_d;
`ifdef FIFO_UART_TX_PARITY_EN
         par_q   <= par_d;
`endif
         if (state == STOP && tick) begin
            frame_cnt <= frame_cnt + 16'd1;
         end
      end
   end

   always_comb begin
      state_d = state;
      shift_d = shift_q;
      idx_d   = idx_q;
`ifdef FIFO_UART_TX_PARITY_EN
      par_d   = par_q;
`endif
      case (state)
         IDLE:  if (tx_en && !empty) state_d = POP;
         POP:   state_d = LOAD;
         LOAD: begin
            shift_d = fifo_data;
`ifdef FIFO_UART_TX_PARITY_EN
            par_d   = ^fifo_data;
`endif
            state_d = START;
         end
         START: begin
            if (tick) begin
               idx_d   = '0;
               state_d = DATA;
            end
         end
         DATA: begin
            if (tick) begin
               shift_d = shift_q >> 1;
               idx_d   = idx_q + IDX_W'(1);
               if (idx_q == LAST_IDX) begin
`ifdef FIFO_UART_TX_PARITY_EN
                  state_d = PARITY;
`else
                  state_d = STOP;
`endif
               end
            end
         end
`ifdef FIFO_UART_TX_PARITY_EN
         PARITY: if (tick) state_d = STOP;
`endif
         STOP:  if (tick) state_d = (tx_en && !empty) ? POP : IDLE;
         default: state_d = IDLE;
      endcase

      // tx is registered from the upcoming state so the line changes on the state boundary.
      case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = shift_d[0];
`ifdef FIFO_UART_TX_PARITY_EN
         PARITY:  tx_d = par_d;
`endif
         default: tx_d = TX_IDLE;
      endcase
   end

   assign read = (state == POP);
   assign busy = (state != IDLE);

endmodule
